// File: rtl/bus_control_unit.sv
// bus_control_unit: arbitrates the external bus between prefetch and EU and sequences each bus cycle
module bus_control_unit #(
  parameter int ADDRESS_WIDTH = 20
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pf_request,
  input  logic [ADDRESS_WIDTH-1:0] pf_address,
  input  logic                     pf_flush,
  output logic                     pf_push,
  output logic                     pf_single,
  input  logic [2:0]               eu_command,
  input  logic [ADDRESS_WIDTH-1:0] eu_address,
  input  logic                     eu_word,
  input  logic [15:0]              eu_write_data,
  output logic                     eu_done,
  output logic [15:0]              eu_read_data,
  input  logic                     readyb,
  input  logic [15:0]              data_in,
  output logic [ADDRESS_WIDTH-1:0] address_out,
  output logic [15:0]              data_out,
  output logic [3:0]               bus_status,
  output logic                     bus_upper_byte_enable
);
  typedef enum logic [1:0] {IDLE, PREFETCH, EU_FIRST, EU_SECOND} state_t;
  state_t state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [3:0] status_q, status_d;
  logic [15:0] dout_q, dout_d;
  logic ube_q, ube_d, split_q, split_d, odd_q, odd_d, single_q, single_d, flush_q, flush_d;
  logic [7:0] hi_q, hi_d, lo_q, lo_d;
  logic eu_valid;
  logic [3:0] eu_status;
  assign eu_valid = eu_command inside {3'd1, 3'd2, 3'd3, 3'd4};
  assign eu_status = eu_command == 3'd2 ? 4'b1010 : eu_command == 3'd3 ? 4'b0101 :
                     eu_command == 3'd4 ? 4'b0110 : 4'b1001;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    status_d = status_q;
    dout_d = dout_q;
    ube_d = ube_q;
    split_d = split_q;
    odd_d = odd_q;
    single_d = single_q;
    flush_d = flush_q;
    hi_d = hi_q;
    lo_d = lo_q;
    case (state_q)
      IDLE:
        if (eu_valid) begin
          state_d = EU_FIRST;
          addr_d = eu_address;
          status_d = eu_status;
          ube_d = eu_word | eu_address[0];
          split_d = eu_word & eu_address[0];
          odd_d = eu_address[0];
          hi_d = eu_write_data[15:8];
          dout_d = eu_address[0] ? {eu_write_data[7:0], 8'h00} :
                   eu_word ? eu_write_data : {8'h00, eu_write_data[7:0]};
        end else if (pf_request) begin
          state_d = PREFETCH;
          addr_d = pf_address;
          status_d = 4'b1001;
          ube_d = 1'b1;
          single_d = pf_address[0];
          dout_d = '0;
        end
      PREFETCH: begin
        flush_d = flush_q | pf_flush;
        state_d = readyb ? PREFETCH : IDLE;
      end
      EU_FIRST:
        if (!readyb) begin
          state_d = split_q ? EU_SECOND : IDLE;
          lo_d = data_in[15:8];
          addr_d = split_q ? addr_q + ADDRESS_WIDTH'(1) : addr_q;
          ube_d = 1'b0;
          dout_d = split_q ? {8'h00, hi_q} : dout_q;
        end
      default: state_d = readyb ? EU_SECOND : IDLE;
    endcase
    if (state_d == IDLE) begin
      status_d = 4'hF;
      ube_d = 1'b0;
      flush_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q <= '1;
      status_q <= 4'hF;
      dout_q <= '0;
      ube_q <= 1'b0;
      split_q <= 1'b0;
      odd_q <= 1'b0;
      single_q <= 1'b0;
      flush_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      status_q <= status_d;
      dout_q <= dout_d;
      ube_q <= ube_d;
      split_q <= split_d;
      odd_q <= odd_d;
      single_q <= single_d;
      flush_q <= flush_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end
  assign pf_push = state_q == PREFETCH && !readyb && !flush_q;
  assign pf_single = state_q == PREFETCH && single_q;
  assign eu_done = ((state_q == EU_FIRST && !split_q) || state_q == EU_SECOND) && !readyb;
  assign eu_read_data = !eu_done ? 16'h0000 :
                        state_q == EU_SECOND ? {data_in[7:0], lo_q} :
                        odd_q ? {8'h00, data_in[15:8]} :
                        ube_q ? data_in : {8'h00, data_in[7:0]};
  assign address_out = addr_q;
  assign data_out = dout_q;
  assign bus_status = status_q;
  assign bus_upper_byte_enable = ube_q;
endmodule

// File: tb/tb_bus_control_unit.sv
// tb_bus_control_unit: randomized scoreboard bench for bus_control_unit against a transaction-level model
module tb_bus_control_unit;
  logic clk = 1'b0, reset = 1'b1, pf_request = 1'b0, pf_flush = 1'b0, eu_word = 1'b0, readyb = 1'b1;
  logic [19:0] pf_address = '0, eu_address = '0;
  logic [2:0] eu_command = '0;
  logic [15:0] eu_write_data = '0, data_in = '0;
  logic pf_push, pf_single, eu_done, ube;
  logic [15:0] eu_read_data, data_out;
  logic [19:0] address_out;
  logic [3:0] bus_status;
  int errors = 0, checks = 0;
  typedef struct {bit is_pf; bit chk; logic [15:0] data; bit single;} exp_t;
  exp_t sb[$];
  exp_t e;
  bus_control_unit dut (
    .clk(clk), .reset(reset), .pf_request(pf_request), .pf_address(pf_address), .pf_flush(pf_flush),
    .pf_push(pf_push), .pf_single(pf_single), .eu_command(eu_command), .eu_address(eu_address),
    .eu_word(eu_word), .eu_write_data(eu_write_data), .eu_done(eu_done), .eu_read_data(eu_read_data),
    .readyb(readyb), .data_in(data_in), .address_out(address_out), .data_out(data_out),
    .bus_status(bus_status), .bus_upper_byte_enable(ube)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (pf_push || eu_done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: pf_push=%0b eu_done=%0b with nothing expected", pf_push, eu_done);
      end else begin
        e = sb.pop_front();
        check("out_kind", {30'd0, pf_push, eu_done}, e.is_pf ? 32'd2 : 32'd1);
        if (e.is_pf) check("pf_single", {31'd0, pf_single}, {31'd0, e.single});
        else if (e.chk) check("eu_read_data", {16'd0, eu_read_data}, {16'd0, e.data});
      end
    end
  end
  task automatic eu_access(input logic [2:0] cmd, input logic [19:0] a, input logic w,
                           input logic [15:0] wd, input int maxwait);
    logic [19:0] ca[2];
    logic cu[2];
    logic [15:0] d[2];
    logic [3:0] st;
    logic [15:0] expd;
    bit rd;
    int n;
    n = (w && a[0]) ? 2 : 1;
    ca[0] = a;
    ca[1] = a + 20'd1;
    cu[0] = w | a[0];
    cu[1] = 1'b0;
    st = cmd == 3'd1 ? 4'b1001 : cmd == 3'd2 ? 4'b1010 : cmd == 3'd3 ? 4'b0101 : 4'b0110;
    rd = cmd == 3'd1 || cmd == 3'd3;
    eu_command = cmd;
    eu_address = a;
    eu_word = w;
    eu_write_data = wd;
    tick;
    eu_command = 3'd0;
    eu_address = 20'($urandom);
    eu_word = 1'($urandom);
    eu_write_data = 16'($urandom);
    for (int k = 0; k < n; k++) begin
      int ws;
      ws = int'($urandom_range(maxwait, 0));
      for (int j = 0; j <= ws; j++) begin
        check("eu_address", {12'd0, address_out}, {12'd0, ca[k]});
        check("eu_status", {28'd0, bus_status}, {28'd0, st});
        check("eu_ube", {31'd0, ube}, {31'd0, cu[k]});
        if (!rd) begin
          if (k == 1) check("wr_second_lo", {24'd0, data_out[7:0]}, {24'd0, wd[15:8]});
          else if (a[0]) check("wr_odd_hi", {24'd0, data_out[15:8]}, {24'd0, wd[7:0]});
          else if (w) check("wr_word", {16'd0, data_out}, {16'd0, wd});
          else check("wr_even_lo", {24'd0, data_out[7:0]}, {24'd0, wd[7:0]});
        end
        if (j < ws) tick;
      end
      d[k] = 16'($urandom);
      data_in = d[k];
      readyb = 1'b0;
      if (k == n - 1) begin
        expd = !w ? (a[0] ? {8'h00, d[0][15:8]} : {8'h00, d[0][7:0]}) :
               a[0] ? {d[1][7:0], d[0][15:8]} : d[0];
        sb.push_back('{0, rd, expd, 0});
      end
      @(negedge clk);
      #1;
      check("eu_drained", sb.size(), 0);
      @(posedge clk);
      #1;
      readyb = 1'b1;
    end
    check("idle_status", {28'd0, bus_status}, 32'hF);
    check("idle_addr_hold", {12'd0, address_out}, {12'd0, ca[n-1]});
  endtask
  task automatic pf_access(input logic [19:0] a, input int maxwait, input bit flush);
    int ws;
    pf_request = 1'b1;
    pf_address = a;
    tick;
    pf_request = 1'b0;
    pf_address = 20'($urandom);
    ws = flush ? 3 : int'($urandom_range(maxwait, 0));
    for (int j = 0; j <= ws; j++) begin
      check("pf_address", {12'd0, address_out}, {12'd0, a});
      check("pf_status", {28'd0, bus_status}, 32'h9);
      check("pf_ube", {31'd0, ube}, 32'd1);
      pf_flush = flush && j == 1;
      if (j < ws) tick;
    end
    pf_flush = 1'b0;
    data_in = 16'($urandom);
    readyb = 1'b0;
    if (!flush) sb.push_back('{1, 0, 16'h0, a[0]});
    @(negedge clk);
    #1;
    check("pf_drained", sb.size(), 0);
    @(posedge clk);
    #1;
    readyb = 1'b1;
    check("pf_idle_status", {28'd0, bus_status}, 32'hF);
  endtask
  task automatic check_reset_values;
    check("rst_address", {12'd0, address_out}, 32'hFFFFF);
    check("rst_status", {28'd0, bus_status}, 32'hF);
    check("rst_data_out", {16'd0, data_out}, 32'd0);
    check("rst_ube", {31'd0, ube}, 32'd0);
    check("rst_read_data", {16'd0, eu_read_data}, 32'd0);
    check("rst_pf_push", {31'd0, pf_push}, 32'd0);
    check("rst_pf_single", {31'd0, pf_single}, 32'd0);
    check("rst_eu_done", {31'd0, eu_done}, 32'd0);
  endtask
  initial begin
    readyb = 1'b0;
    repeat (3) tick;
    check_reset_values;
    readyb = 1'b1;
    reset = 1'b0;
    pf_access(20'hFFFF0, 0, 0);
    tick;
    pf_request = 1'b1;
    pf_address = 20'h00500;
    eu_access(3'd2, 20'h00100, 1'b1, 16'hBEEF, 0);
    pf_access(20'h00500, 1, 0);
    tick;
    eu_access(3'd1, 20'h00103, 1'b1, 16'h0000, 1);
    tick;
    eu_access(3'd4, 20'h00041, 1'b0, 16'h00A5, 0);
    tick;
    eu_access(3'd3, 20'hFFFFF, 1'b1, 16'h0000, 2);
    tick;
    eu_access(3'd1, 20'h00042, 1'b0, 16'h0000, 1);
    tick;
    pf_access(20'h00201, 0, 1);
    tick;
    pf_access(20'h00203, 1, 0);
    tick;
    eu_command = 3'd1;
    eu_address = 20'h00203;
    eu_word = 1'b1;
    tick;
    eu_command = 3'd0;
    check("mid_addr", {12'd0, address_out}, 32'h00203);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check_reset_values;
    readyb = 1'b0;
    tick;
    check("post_reset_idle", {28'd0, bus_status}, 32'hF);
    readyb = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick;
      if ($urandom_range(1, 0) == 1)
        eu_access(3'($urandom_range(4, 1)), ($urandom_range(7, 0) == 0) ? 20'hFFFFF : 20'($urandom),
                  1'($urandom), 16'($urandom), 2);
      else
        pf_access(20'($urandom), 2, $urandom_range(3, 0) == 0);
    end
    tick;
    check("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
